// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  // Receiver FSM states.
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } rx_state_t;

  // 25 MHz system clock at 115200 baud.
  localparam int unsigned c_CLKS_PER_BIT_115200 = 217;

  // Clock count from the falling edge to the middle of the start bit.
  function automatic int unsigned half_bit(input int unsigned clks_per_bit);
    return (clks_per_bit - 1) / 2;
  endfunction

endpackage

// File: rtl/bit_sync.sv
// Two-flop synchronizer for a single asynchronous input bit.
module bit_sync #(
  parameter logic ResetVal = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Both stages reset to the line's idle level so reset never looks like an edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= ResetVal;
      sync_q <= ResetVal;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_start.sv
// 8N1 UART receiver: one-cycle strobe per good byte, framing-error strobe,
// glitch rejection and line-break lockout.
module uart_rx_start
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = c_CLKS_PER_BIT_115200
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_RX_Serial,
  output logic       o_RX_DV,
  output logic [7:0] o_RX_Byte,
  output logic       o_Frame_Err,
  output logic       o_Busy
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(half_bit(CLKS_PER_BIT));
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  logic            rx_s;
  rx_state_t       state_q;
  logic [CntW-1:0] clk_cnt_q;
  logic [2:0]      bit_idx_q;
  logic [7:0]      shift_q;
  logic [7:0]      rx_byte_q;
  logic            rx_dv_q;
  logic            frame_err_q;

  bit_sync #(
    .ResetVal(1'b1)
  ) u_rx_sync (
    .clk_i (i_Clk),
    .rst_ni(i_Rst_L),
    .d_i   (i_RX_Serial),
    .q_o   (rx_s)
  );

  // Frame FSM with registered strobes; the line is only looked at on counter points.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q     <= IDLE;
      clk_cnt_q   <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      rx_byte_q   <= '0;
      rx_dv_q     <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_dv_q     <= 1'b0;
      frame_err_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          clk_cnt_q <= '0;
          bit_idx_q <= '0;
          if (!rx_s) begin
            state_q <= START;
          end
        end
        START: begin
          if (clk_cnt_q == CntHalf) begin
            clk_cnt_q <= '0;
            // A line already back high at mid start bit is a glitch.
            state_q   <= rx_s ? IDLE : DATA;
          end else begin
            clk_cnt_q <= clk_cnt_q + CntOne;
          end
        end
        DATA: begin
          if (clk_cnt_q == CntLast) begin
            clk_cnt_q          <= '0;
            shift_q[bit_idx_q] <= rx_s;
            if (bit_idx_q == 3'd7) begin
              state_q <= STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + CntOne;
          end
        end
        STOP: begin
          if (clk_cnt_q == CntLast) begin
            clk_cnt_q <= '0;
            if (rx_s) begin
              rx_byte_q <= shift_q;
              rx_dv_q   <= 1'b1;
              state_q   <= IDLE;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= WAIT_HIGH;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + CntOne;
          end
        end
        WAIT_HIGH: begin
          // Held-low line (break): do not re-arm until it returns high.
          clk_cnt_q <= '0;
          bit_idx_q <= '0;
          if (rx_s) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign o_RX_DV     = rx_dv_q;
  assign o_RX_Byte   = rx_byte_q;
  assign o_Frame_Err = frame_err_q;
  assign o_Busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_start.sv
// Bench for uart_rx_start: a fast-baud instance (4 clocks/bit) checked every cycle
// against an expected-event/busy-interval model, and a default-baud instance fed jittered bits.
module tb_uart_rx_start;

  localparam int unsigned CpbA  = 4;
  localparam int unsigned HalfA = (CpbA - 1) / 2;
  localparam int unsigned CpbB  = 217;
  localparam int unsigned HalfB = (CpbB - 1) / 2;

  typedef struct {
    int unsigned cyc;
    bit          fe;
    logic [7:0]  b;
  } ev_t;

  typedef struct {
    int unsigned s;
    int unsigned e;
  } iv_t;

  logic       clk;
  logic       rst_a, rst_b;
  logic       line_a, line_b;
  logic       dv_a, fe_a, busy_a;
  logic       dv_b, fe_b, busy_b;
  logic [7:0] rxb_a, rxb_b;

  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  ev_t ev_a[$];
  iv_t bz_a[$];
  logic [7:0]  mdl_byte_a = 8'h00;
  logic [7:0]  mdl_byte_b = 8'h00;
  int unsigned exp_b_cyc = 0;
  logic [7:0]  exp_b_byte = 8'h00;
  int          dv_cnt_b = 0;

  uart_rx_start #(
    .CLKS_PER_BIT(CpbA)
  ) u_dut_a (
    .i_Clk      (clk),
    .i_Rst_L    (rst_a),
    .i_RX_Serial(line_a),
    .o_RX_DV    (dv_a),
    .o_RX_Byte  (rxb_a),
    .o_Frame_Err(fe_a),
    .o_Busy     (busy_a)
  );

  uart_rx_start #(
    .CLKS_PER_BIT(CpbB)
  ) u_dut_b (
    .i_Clk      (clk),
    .i_Rst_L    (rst_b),
    .i_RX_Serial(line_b),
    .o_RX_DV    (dv_b),
    .o_RX_Byte  (rxb_b),
    .o_Frame_Err(fe_b),
    .o_Busy     (busy_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Frame on line A; starts at an aligned time (#1 after an edge), returns likewise.
  task automatic send_a(input logic [7:0] data, input logic stop, output int unsigned t0);
    logic [9:0] frame;
    ev_t ev;
    iv_t iv;
    frame = {stop, data, 1'b0};
    t0 = cyc + 1;
    ev.cyc = t0 + 3 + HalfA + 9 * CpbA;
    ev.fe  = !stop;
    ev.b   = data;
    ev_a.push_back(ev);
    iv.s = t0 + 2;
    iv.e = stop ? ev.cyc : 32'hFFFF_FFFF;
    bz_a.push_back(iv);
    for (int i = 0; i < 10; i++) begin
      line_a = frame[i];
      repeat (CpbA) @(posedge clk);
      #1;
    end
  endtask

  // Good frame on line B with each bit length jittered by up to +/-4 clocks.
  task automatic send_b(input logic [7:0] data);
    logic [9:0] frame;
    int unsigned t0;
    frame = {1'b1, data, 1'b0};
    t0 = cyc + 1;
    exp_b_cyc  = t0 + 3 + HalfB + 9 * CpbB;
    exp_b_byte = data;
    for (int i = 0; i < 10; i++) begin
      line_b = frame[i];
      repeat (CpbB - 4 + $urandom_range(8)) @(posedge clk);
      #1;
    end
  endtask

  // Per-cycle compare against the model, sampled away from the active edge.
  always @(negedge clk) begin
    logic exp_dv, exp_fe, exp_busy, exp_dv_b;
    exp_dv = 1'b0;
    exp_fe = 1'b0;
    if (!rst_a) begin
      ev_a.delete();
      bz_a.delete();
      mdl_byte_a = 8'h00;
    end else if (ev_a.size() > 0 && ev_a[0].cyc == cyc) begin
      exp_dv = !ev_a[0].fe;
      exp_fe = ev_a[0].fe;
      if (!ev_a[0].fe) mdl_byte_a = ev_a[0].b;
      void'(ev_a.pop_front());
    end
    while (bz_a.size() > 0 && bz_a[0].e <= cyc) void'(bz_a.pop_front());
    exp_busy = (bz_a.size() > 0 && bz_a[0].s <= cyc);
    chk("a_dv", 32'(dv_a), 32'(exp_dv));
    chk("a_frame_err", 32'(fe_a), 32'(exp_fe));
    chk("a_byte", 32'(rxb_a), 32'(mdl_byte_a));
    chk("a_busy", 32'(busy_a), 32'(exp_busy));

    exp_dv_b = (cyc == exp_b_cyc);
    if (exp_dv_b) mdl_byte_b = exp_b_byte;
    if (dv_b) dv_cnt_b++;
    chk("b_dv", 32'(dv_b), 32'(exp_dv_b));
    chk("b_frame_err", 32'(fe_b), 32'(1'b0));
    chk("b_byte", 32'(rxb_b), 32'(mdl_byte_b));
  end

  initial begin
    #1_000_000;
    n_errors++;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned t0, r;
    rst_a  = 1'b0;
    rst_b  = 1'b0;
    line_a = 1'b1;
    line_b = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_dv", 32'(dv_a), 32'(1'b0));
    chk("reset_byte", 32'(rxb_a), 32'h00);
    chk("reset_busy", 32'(busy_a), 32'(1'b0));
    chk("reset_frame_err", 32'(fe_a), 32'(1'b0));
    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Good byte: strobe after edge t0+40, one cycle wide.
    send_a(8'hA5, 1'b1, t0);
    @(posedge clk);
    #1;
    chk("good_dv_at_t0p40", 32'(dv_a), 32'(1'b1));
    chk("good_byte", 32'(rxb_a), 32'hA5);
    chk("good_cycle", cyc, t0 + 40);
    @(posedge clk);
    #1;
    chk("good_dv_one_cycle", 32'(dv_a), 32'(1'b0));
    repeat (3) @(posedge clk);
    #1;

    // Back-to-back 00 then FF.
    send_a(8'h00, 1'b1, t0);
    send_a(8'hFF, 1'b1, t0);
    @(posedge clk);
    #1;
    chk("b2b_second_dv", 32'(dv_a), 32'(1'b1));
    chk("b2b_second_byte", 32'(rxb_a), 32'hFF);
    repeat (3) @(posedge clk);
    #1;

    // One-cycle glitch.
    line_a = 1'b0;
    t0 = cyc + 1;
    bz_a.push_back('{s: t0 + 2, e: t0 + 4});
    @(posedge clk);
    #1;
    line_a = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("glitch_busy_rises", 32'(busy_a), 32'(1'b1));
    repeat (3) @(posedge clk);
    #1;
    chk("glitch_busy_falls", 32'(busy_a), 32'(1'b0));

    // Framing error then line break of about 100 cycles.
    send_a(8'h3C, 1'b0, t0);
    @(posedge clk);
    #1;
    chk("fe_pulse", 32'(fe_a), 32'(1'b1));
    chk("fe_byte_kept", 32'(rxb_a), 32'hFF);
    chk("fe_no_dv", 32'(dv_a), 32'(1'b0));
    repeat (95) @(posedge clk);
    #1;
    chk("break_busy", 32'(busy_a), 32'(1'b1));
    line_a = 1'b1;
    r = cyc + 1;
    bz_a[bz_a.size() - 1].e = r + 2;
    repeat (4) @(posedge clk);
    #1;
    chk("break_release_idle", 32'(busy_a), 32'(1'b0));
    send_a(8'h55, 1'b1, t0);
    @(posedge clk);
    #1;
    chk("after_fe_dv", 32'(dv_a), 32'(1'b1));
    chk("after_fe_byte", 32'(rxb_a), 32'h55);
    repeat (3) @(posedge clk);
    #1;

    // Reset asserted during data bit 3 of C3 and held to the end of that frame.
    fork
      send_a(8'hC3, 1'b1, t0);
      begin
        repeat (18) @(posedge clk);
        #1;
        chk("mid_frame_busy", 32'(busy_a), 32'(1'b1));
        #2;
        rst_a = 1'b0;
        #1;
        chk("async_rst_busy", 32'(busy_a), 32'(1'b0));
        chk("async_rst_byte", 32'(rxb_a), 32'h00);
        chk("async_rst_dv", 32'(dv_a), 32'(1'b0));
      end
    join
    @(posedge clk);
    #1;
    rst_a = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    send_a(8'h12, 1'b1, t0);
    @(posedge clk);
    #1;
    chk("post_rst_dv", 32'(dv_a), 32'(1'b1));
    chk("post_rst_byte", 32'(rxb_a), 32'h12);
    repeat (3) @(posedge clk);
    #1;

    // Default baud with jittered bit timing.
    send_b(8'h47);
    repeat (5) @(posedge clk);
    #1;
    chk("baud217_byte", 32'(rxb_b), 32'h47);
    chk("baud217_dv_width", 32'(dv_cnt_b), 32'd1);
    chk("baud217_idle", 32'(busy_b), 32'(1'b0));

    repeat (5) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
